// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier front end.
// The multiply is split into four 4x4 nibble products accumulated over C0..C3.
package seq_mult_pkg;

  localparam int W_IN  = 8;
  localparam int W_OUT = 16;
  localparam int NIB   = 4;

  localparam int SH0 = 0;
  localparam int SH4 = 4;
  localparam int SH8 = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C0   = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    C3   = 3'd4,
    DONE = 3'd5
  } mult_state_t;

  // Select the high or low nibble of an operand.
  function automatic logic [NIB-1:0] nib_sel(input logic [W_IN-1:0] v, input logic hi);
    return hi ? v[W_IN-1:NIB] : v[NIB-1:0];
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Handshake and accumulator-path bundle between the multiplier front end,
// its requester and the downstream reg16 accumulator.
interface seq_mult_ctrl_if;
  import seq_mult_pkg::*;

  logic             start;
  logic [W_IN-1:0]  dataa;
  logic [W_IN-1:0]  datab;
  logic             busy;
  logic             done;
  logic [W_OUT-1:0] acc_q;
  logic [W_OUT-1:0] acc_next;
  logic             acc_clk_ena;
  logic             acc_sclr_n;

  modport master (
    output start, dataa, datab, acc_q,
    input  busy, done, acc_next, acc_clk_ena, acc_sclr_n
  );

  modport slave (
    input  start, dataa, datab, acc_q,
    output busy, done, acc_next, acc_clk_ena, acc_sclr_n
  );

endinterface

// File: rtl/mult4x4.sv
// Combinational 4x4 unsigned multiplier with a full-width 8-bit result.
module mult4x4
  import seq_mult_pkg::*;
(
  input  logic [NIB-1:0]   a,
  input  logic [NIB-1:0]   b,
  output logic [2*NIB-1:0] p
);

  assign p = (2*NIB)'(a) * (2*NIB)'(b);

endmodule

// File: rtl/reg16.sv
// Downstream 16-bit accumulator register: synchronous clear wins over enable.
module reg16
  import seq_mult_pkg::*;
(
  input  logic             clk,
  input  logic [W_OUT-1:0] datain,
  input  logic             clk_ena,
  input  logic             sclr_n,
  output logic [W_OUT-1:0] reg_out
);

  always_ff @(posedge clk) begin
    if (!sclr_n)
      reg_out <= '0;
    else if (clk_ena)
      reg_out <= datain;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer and accumulate path for the 8x8 multiplier: one nibble product per
// cycle is shifted and added to the reg16 value read back on acc_q.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic          clk,
  input  logic          sclr,
  seq_mult_ctrl_if.slave bus
);

  mult_state_t state, state_nx;

  logic [W_IN-1:0]    a_r, b_r;
  logic               accept;
  logic               a_hi_sel, b_hi_sel;
  logic [3:0]         sh;
  logic               use_acc;
  logic               ena;
  logic [NIB-1:0]     a_nib, b_nib;
  logic [2*NIB-1:0]   pp;
  logic [W_OUT-1:0]   pp_sh;
  logic [W_OUT-1:0]   base;
  logic [W_OUT:0]     sum;
  logic               add_carry;

  // New operands are only taken when no multiply is in flight.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (sclr)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      a_r <= '0;
      b_r <= '0;
    end else if (accept) begin
      a_r <= bus.dataa;
      b_r <= bus.datab;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.start ? C0 : IDLE;
      C0:      state_nx = C1;
      C1:      state_nx = C2;
      C2:      state_nx = C3;
      C3:      state_nx = DONE;
      DONE:    state_nx = bus.start ? C0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ena      = 1'b0;
    use_acc  = 1'b0;
    a_hi_sel = 1'b0;
    b_hi_sel = 1'b0;
    sh       = 4'(SH0);
    unique case (state)
      C0: ena = 1'b1;
      C1: begin
        ena      = 1'b1;
        use_acc  = 1'b1;
        a_hi_sel = 1'b1;
        sh       = 4'(SH4);
      end
      C2: begin
        ena      = 1'b1;
        use_acc  = 1'b1;
        b_hi_sel = 1'b1;
        sh       = 4'(SH4);
      end
      C3: begin
        ena      = 1'b1;
        use_acc  = 1'b1;
        a_hi_sel = 1'b1;
        b_hi_sel = 1'b1;
        sh       = 4'(SH8);
      end
      default: ;
    endcase
  end

  assign a_nib = nib_sel(a_r, a_hi_sel);
  assign b_nib = nib_sel(b_r, b_hi_sel);

  mult4x4 u_mult4x4 (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // C0 ignores acc_q so a stale register value never leaks into the product.
  assign pp_sh     = W_OUT'(pp) << sh;
  assign base      = use_acc ? bus.acc_q : '0;
  assign sum       = {1'b0, base} + {1'b0, pp_sh};
  assign add_carry = sum[W_OUT];

  assign bus.acc_next    = ena ? sum[W_OUT-1:0] : '0;
  assign bus.acc_clk_ena = ena;
  assign bus.acc_sclr_n  = ~sclr;
  assign bus.busy        = ena;
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and random checks of seq_mult_ctrl closed around a reg16 accumulator.
module tb_seq_mult_ctrl;
  import seq_mult_pkg::*;

  logic clk;
  logic sclr;
  int   n_checks;
  int   n_err;

  seq_mult_ctrl_if bus ();

  seq_mult_ctrl dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus)
  );

  reg16 u_reg16 (
    .clk     (clk),
    .datain  (bus.acc_next),
    .clk_ena (bus.acc_clk_ena),
    .sclr_n  (bus.acc_sclr_n),
    .reg_out (bus.acc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accumulator value after step k (0..3) from the nibble decomposition of a*b.
  function automatic logic [15:0] ref_step(input logic [7:0] a, input logic [7:0] b, input int k);
    int al, ah, bl, bh, s;
    al = int'(a) % 16;
    ah = int'(a) / 16;
    bl = int'(b) % 16;
    bh = int'(b) / 16;
    s  = al * bl;
    if (k >= 1) s += ah * bl * 16;
    if (k >= 2) s += al * bh * 16;
    if (k >= 3) s += ah * bh * 256;
    return 16'(s);
  endfunction

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("acc_step", bus.acc_q, ref_step(a, b, k));
      check("busy", bus.busy, (k < 3) ? 1 : 0);
      check("done", bus.done, (k == 3) ? 1 : 0);
      if (k < 3) check("carry", dut.add_carry, 0);
    end
    check("product", bus.acc_q, a * b);
    @(posedge clk);
    @(negedge clk);
    check("done_width", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    sclr      = 1'b1;
    bus.start = 1'b0;
    bus.dataa = 'x;
    bus.datab = 'x;

    // Reset held for two cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_state", dut.state, IDLE);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ena", bus.acc_clk_ena, 0);
    check("rst_next", bus.acc_next, 0);
    check("rst_sclr_n", bus.acc_sclr_n, 0);
    sclr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_reg_out", bus.acc_q, 16'h0000);
    check("rel_sclr_n", bus.acc_sclr_n, 1);
    check("rel_state", dut.state, IDLE);

    // Full scale, including the exact partial-sum sequence.
    bus.dataa = 8'hFF;
    bus.datab = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] fs_seq [4];
      fs_seq = '{16'h00E1, 16'h0EF1, 16'h1D01, 16'hFE01};
      @(posedge clk);
      @(negedge clk);
      check("fs_acc", bus.acc_q, fs_seq[k]);
      check("fs_done", bus.done, (k == 3) ? 1 : 0);
    end
    @(posedge clk);
    @(negedge clk);
    check("fs_done_once", bus.done, 0);
    check("fs_hold", bus.acc_q, 16'hFE01);

    // Operand capture and start filtering, then restart from DONE.
    bus.dataa = 8'hC8;
    bus.datab = 8'h64;
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) begin
        bus.dataa = 8'h11;
        bus.datab = 8'h22;
      end
      if (c <= 3) check("cap_busy", bus.busy, 1);
      check("cap_done", bus.done, (c == 4 || c == 9) ? 1 : 0);
      if (c == 4) check("cap_product", bus.acc_q, 16'h4E20);
      if (c == 5) begin
        check("cap_restart", dut.state, C0);
        bus.start = 1'b0;
      end
      if (c == 6) check("cap_new_c0", bus.acc_q, 16'h0002);
      if (c == 9) check("cap_new_product", bus.acc_q, 16'h0242);
    end
    @(posedge clk);
    @(negedge clk);

    // Back-to-back with start held through DONE.
    bus.dataa = 8'h12;
    bus.datab = 8'h34;
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_done", bus.done, (c == 4 || c == 9) ? 1 : 0);
      if (c == 4 || c == 9) check("b2b_product", bus.acc_q, 16'h03A8);
      if (c == 9) bus.start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle", dut.state, IDLE);

    // Reset asserted for one cycle while in C2.
    bus.dataa = 8'hFF;
    bus.datab = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 sclr = 1'b1;
    check("mid_in_c2", dut.state, C2);
    @(posedge clk);
    #1 sclr = 1'b0;
    @(negedge clk);
    check("mid_state", dut.state, IDLE);
    check("mid_acc", bus.acc_q, 16'h0000);
    check("mid_busy", bus.busy, 0);
    check("mid_a_r", dut.a_r, 0);
    for (int c = 0; c < 5; c++) begin
      check("mid_no_done", bus.done, 0);
      @(posedge clk);
      @(negedge clk);
    end

    // Zero operands.
    run_mult(8'h00, 8'hAB);
    run_mult(8'hAB, 8'h00);

    // Random sweep.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_mult(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Sequencing and accumulate-path front end of the 8x8 sequential multiplier. Accepts a start request with two unsigned 8-bit operands. Forms the four 4x4 partial products over four cycles, shifts each one, and adds it to the current accumulator value. Drives the data, enable and clear inputs of the downstream 16-bit accumulator register (`reg16`) and reads its output back, so the product builds up in that register.

## Interface
- `W_IN`, default 8: operand width; fixed at 8 for this design.
- `W_OUT`, default 16: product / accumulator width.
- `clk`, input, 1: rising-edge clock, shared with `reg16`.
- `sclr`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a multiply; sampled on the clock edge.
- `dataa`, input, 8: multiplicand, unsigned.
- `datab`, input, 8: multiplier, unsigned.
- `acc_q`, input, 16: current `reg16` output (`reg_out`).
- `acc_next`, output, 16: value to load; drives `reg16.datain`.
- `acc_clk_ena`, output, 1: drives `reg16.clk_ena`.
- `acc_sclr_n`, output, 1: drives `reg16.sclr_n`.
- `busy`, output, 1: high in states C0–C3.
- `done`, output, 1: one-cycle pulse; `acc_q` holds the final product while it is high.

## Operation
- States: IDLE, C0, C1, C2, C3, DONE.
- Operand capture: `dataa` and `datab` are captured into internal registers `a_r` and `b_r` on the edge that accepts `start`. Input changes after that edge have no effect on the result.
- Per-state datapath (all widths 16 bits, zero-extended):
  - C0: `acc_next = a_lo*b_lo`. `acc_q` is ignored, so the first product overwrites any stale value.
  - C1: `acc_next = acc_q + (a_hi*b_lo << 4)`.
  - C2: `acc_next = acc_q + (a_lo*b_hi << 4)`.
  - C3: `acc_next = acc_q + (a_hi*b_hi << 8)`.
  - IDLE and DONE: `acc_next = 0`.
- Adder width: 16-bit, carry-out discarded. The maximum product is 255*255 = 0xFE01, so no overflow is possible; the bench checks that the carry is never set.
- Register control:
  - `acc_clk_ena` = 1 in C0–C3, else 0. In IDLE and DONE, `reg16` sees {ena, sclr_n} = 01 and holds its value.
  - `acc_sclr_n` = `~sclr`, combinational. While `sclr` is high, `reg16` clears regardless of enable.
- Transitions:
  - IDLE → C0 on `start`; otherwise stay in IDLE.
  - C0 → C1 → C2 → C3 → DONE, unconditionally.
  - DONE → C0 if `start` (back-to-back multiply, operands recaptured); else DONE → IDLE.
- `start` while `busy`: ignored, not queued.
- `sclr` in any state: next state is IDLE and `a_r`/`b_r` are cleared. The accumulator is cleared through `acc_sclr_n`. A multiply interrupted this way never produces `done`.

## Timing
- Reset values (the cycle after `sclr` is sampled high): state = IDLE, `busy` = 0, `done` = 0, `acc_clk_ena` = 0, `acc_next` = 0. `acc_sclr_n` = 0 for as long as `sclr` is high.
- Latency:
  - `start` sampled at edge E0.
  - `reg16` captures the C0..C3 values at edges E1..E4.
  - `done` = 1 in the cycle between E4 and E5, with `acc_q` = the final product in that cycle.
  - Start-to-result: 4 clocks. The back-to-back repeat interval is 5 clocks.
- After `done`: the product stays on `acc_q` until the next C0 load or `sclr`.
- `busy` and `done` are registered-state decodes, so they have no combinational path from `start`.

## Structure
- Package `seq_mult_pkg`:
  - state enum `mult_state_t` (IDLE, C0, C1, C2, C3, DONE);
  - constants `W_IN`, `W_OUT`, `NIB` = 4;
  - shift constants `SH0` = 0, `SH4` = 4, `SH8` = 8.
- One sub-module, `mult4x4`: a combinational 4x4 unsigned multiplier with an 8-bit result, instantiated once. Nibble selection and the shift are muxed in front of and behind it per state.
- Top level contains: the FSM, operand registers, nibble muxes, shifter and 16-bit adder.
- The bench instantiates `seq_mult_ctrl` together with `reg16` and closes the `acc_q` loop.

## Test plan
- Reset: hold `sclr` = 1 for 2 cycles from an X state. Required: IDLE, `busy` = 0, `done` = 0, `acc_sclr_n` = 0; `reg_out` = 0x0000 after the release edge.
- Full scale: `dataa` = 0xFF, `datab` = 0xFF, pulse `start`. Required `acc_q` sequence: 0x00E1, 0x0EF1, 0x1D01, 0xFE01. `done` is high exactly 1 cycle, in the cycle after E4.
- Operand capture and start filtering: `dataa` = 0xC8, `datab` = 0x64, `start`; then hold `start` = 1 and change the operands to 0x11/0x22 during C1–C3. Required: product 0x4E20, no restart before DONE, then a C0 restart from DONE.
- Back-to-back: `start` held through DONE with `dataa` = 0x12, `datab` = 0x34. Required: second product 0x03A8, with `done` pulses 5 cycles apart.
- Reset mid-operation: assert `sclr` for 1 cycle in C2. Required: IDLE next cycle, `acc_q` = 0x0000, no `done` pulse.
- Zero and carry check: 0x00 * 0xAB gives 0x0000, and 0xAB * 0x00 gives 0x0000. Adder carry-out = 0 across a random sweep of 200 pairs, with every product matching `dataa*datab`.
